ub_sequencer: RTL and testbench
===============================

Name: ub_sequencer

Overview:
Command-driven controller for the unified buffer (UB). It accepts one command at a time: LOAD tiles to input_setup, STORE accumulator results, or RUN (load then store). It drives the UB addr, load_input and store strobes and handshakes with input_setup and the two accumulators. It sits between the top-level control FSM and the UB; it is the only master of the UB control pins.

Parameters:
ADDR_W, 13, UB address width
MEM_SIZE, 32, UB depth in bytes; used for the range check
TILE, 4, bytes moved per UB access (fixed 2x2 tile)
CNT_W, 4, width of the tile-count field

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  sequencer can accept a command; high only in IDLE
cmd_op  in  2  0=NOP, 1=LOAD, 2=STORE, 3=RUN
cmd_src  in  ADDR_W  base address for loads
cmd_dst  in  ADDR_W  base address for stores
cmd_tiles  in  CNT_W  number of tiles, 0..15
setup_ready  in  1  input_setup can accept a tile
setup_valid  out  1  UB out_ub_* hold a valid tile this cycle
acc1_full  in  1  accumulator 1 full
acc2_full  in  1  accumulator 2 full
acc_clear  out  1  one-cycle pulse; accumulators drop full
ub_addr  out  ADDR_W  UB address
ub_load_input  out  1  UB read strobe
ub_store  out  1  UB write strobe
busy  out  1  not IDLE
done  out  1  one-cycle completion pulse
err  out  1  one-cycle rejection pulse

Behaviour:
- Reset values: all outputs 0 except cmd_ready=1. State=IDLE; counters and latched command cleared. Reset mid-command aborts immediately; no further strobes are issued.
- All outputs are registered. Accept on cmd_valid && cmd_ready, latching op, src, dst and tiles.
- Range check at accept, using widened arithmetic with no wrap:
  - LOAD/RUN: error if cmd_src + TILE*cmd_tiles > MEM_SIZE.
  - STORE/RUN: error if cmd_dst + TILE*cmd_tiles > MEM_SIZE.
  - On error: err pulses the next cycle, no UB strobes, return to IDLE, done is not pulsed.
- NOP, or cmd_tiles==0: done pulses the next cycle, with no strobes.
- States:
  - IDLE -> LOAD (op LOAD/RUN) or WAIT_ACC (op STORE).
  - LOAD: in each cycle with setup_ready=1, assert ub_load_input=1 and ub_addr=src+TILE*k, then k++. If setup_ready=0, no strobe and hold. After the last tile: LOAD -> DONE for LOAD, LOAD -> WAIT_ACC for RUN (k reset to 0).
  - WAIT_ACC: when acc1_full && acc2_full are sampled high in the same cycle, go to STORE. A single flag high does nothing.
  - STORE: one cycle with ub_store=1, ub_addr=dst+TILE*k and acc_clear=1, then k++. Go back to WAIT_ACC if more tiles remain, else DONE. Full flags must still be high during the STORE cycle, since the UB gates on them; the accumulators hold full until acc_clear.
  - DONE: done=1 for one cycle -> IDLE.
- Back-to-back loads: one tile per cycle while setup_ready stays high.
- setup_valid = ub_load_input delayed one cycle, matching UB read latency.
- ub_load_input and ub_store are never high in the same cycle.
- ub_addr holds its last value when no strobe is active.
- cmd_valid outside IDLE is ignored; cmd_ready=0.

Decomposition:
- Package ub_seq_pkg:
  - op enum (OP_NOP, OP_LOAD, OP_STORE, OP_RUN)
  - state enum (IDLE, LOAD, WAIT_ACC, STORE, DONE)
  - TILE and MEM_SIZE defaults
- Sub-module ub_addr_gen: base latch, tile counter k, address = base + TILE*k, last-tile flag, range check. Instantiated once; the FSM selects src or dst as the base.

Test Plan:
- LOAD src=0 tiles=3, setup_ready=1 -> ub_load_input for 3 consecutive cycles at addr 0,4,8; setup_valid lags one cycle; done one cycle after the last strobe.
- LOAD src=4 tiles=2 with setup_ready low for 2 cycles between tiles -> addr 4, stall, addr 8; no strobe during the stall.
- STORE dst=16 tiles=2; acc1_full rises 3 cycles before acc2_full -> no store until both are high; ub_store and acc_clear at addr 16, then at 20 after the flags re-assert; done pulse.
- RUN src=0 dst=8 tiles=2 -> loads at 0,4, then stores at 8,12, with no overlap of load and store strobes.
- Range error: LOAD src=28 tiles=2 (36>32) -> err pulse, zero strobes, cmd_ready back high. tiles=0 -> done pulse only.
- Assert reset mid-RUN during WAIT_ACC -> all outputs return to reset values; the next command executes normally from IDLE.

Source files
------------

// File: rtl/ub_seq_pkg.sv
// Shared types and defaults for the unified-buffer command sequencer.
package ub_seq_pkg;

  localparam int TILE_DEF     = 4;
  localparam int MEM_SIZE_DEF = 32;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2,
    OP_RUN   = 2'd3
  } ub_op_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    WAIT_ACC = 3'd2,
    STORE    = 3'd3,
    DONE     = 3'd4
  } ub_state_e;

endpackage

// File: rtl/ub_sequencer_if.sv
// Command, input_setup, accumulator and UB-control signals of the sequencer.
interface ub_sequencer_if
  import ub_seq_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int CNT_W  = 4
) ();

  // A command transfers on the clock edge where cmd_valid && cmd_ready are both high;
  // cmd_ready is high only while the sequencer is idle, and cmd_* must be stable while cmd_valid is high.
  logic              cmd_valid;
  logic              cmd_ready;
  ub_op_e            cmd_op;
  logic [ADDR_W-1:0] cmd_src;
  logic [ADDR_W-1:0] cmd_dst;
  logic [CNT_W-1:0]  cmd_tiles;
  logic              setup_ready;
  logic              setup_valid;
  logic              acc1_full;
  logic              acc2_full;
  logic              acc_clear;
  logic [ADDR_W-1:0] ub_addr;
  logic              ub_load_input;
  logic              ub_store;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_tiles,
    input  setup_ready, acc1_full, acc2_full,
    output cmd_ready, setup_valid, acc_clear, ub_addr, ub_load_input, ub_store,
    output busy, done, err
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_tiles,
    output setup_ready, acc1_full, acc2_full,
    input  cmd_ready, setup_valid, acc_clear, ub_addr, ub_load_input, ub_store,
    input  busy, done, err
  );

endinterface

// File: rtl/ub_addr_gen.sv
// Latches the command, walks tile index k and forms base + TILE*k; also range-checks new commands.
module ub_addr_gen
  import ub_seq_pkg::*;
#(
  parameter int ADDR_W   = 13,
  parameter int CNT_W    = 4,
  parameter int TILE     = TILE_DEF,
  parameter int MEM_SIZE = MEM_SIZE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              latch,
  input  ub_op_e            cmd_op,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [CNT_W-1:0]  cmd_tiles,
  input  logic              inc,
  input  logic              clr,
  input  logic              sel_dst,
  output logic [ADDR_W-1:0] addr,
  output logic              last,
  output logic              range_err
);

  localparam int WW = ADDR_W + CNT_W + 4;
  localparam logic [ADDR_W-1:0] TILE_A = ADDR_W'(TILE);

  logic [ADDR_W-1:0] src_q, dst_q;
  logic [CNT_W-1:0]  tiles_q, k_q;
  logic [WW-1:0]     span, src_end, dst_end;
  logic              src_bad, dst_bad;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q   <= '0;
      dst_q   <= '0;
      tiles_q <= '0;
      k_q     <= '0;
    end else if (latch) begin
      src_q   <= cmd_src;
      dst_q   <= cmd_dst;
      tiles_q <= cmd_tiles;
      k_q     <= '0;
    end else if (clr) begin
      k_q <= '0;
    end else if (inc) begin
      k_q <= k_q + CNT_W'(1);
    end
  end

  assign addr = (sel_dst ? dst_q : src_q) + TILE_A * ADDR_W'(k_q);
  assign last = (k_q == tiles_q - CNT_W'(1));

  // Widened so a base near the top of the address space cannot wrap past the check.
  assign span    = WW'(TILE) * WW'(cmd_tiles);
  assign src_end = WW'(cmd_src) + span;
  assign dst_end = WW'(cmd_dst) + span;
  assign src_bad = src_end > WW'(MEM_SIZE);
  assign dst_bad = dst_end > WW'(MEM_SIZE);

  assign range_err = (((cmd_op == OP_LOAD) || (cmd_op == OP_RUN)) && src_bad) ||
                     (((cmd_op == OP_STORE) || (cmd_op == OP_RUN)) && dst_bad);

endmodule

// File: rtl/ub_sequencer.sv
// Single-command UB controller: LOAD tiles to input_setup, STORE accumulator tiles, or RUN both.
module ub_sequencer
  import ub_seq_pkg::*;
#(
  parameter int ADDR_W   = 13,
  parameter int MEM_SIZE = MEM_SIZE_DEF,
  parameter int TILE     = TILE_DEF,
  parameter int CNT_W    = 4
) (
  input  logic           clk,
  input  logic           reset,
  ub_sequencer_if.master bus,
  output ub_state_e      state_dbg
);

  ub_state_e         state_q, state_d;
  ub_op_e            op_q;
  logic              latch, inc, clr, sel_dst, last, range_err;
  logic [ADDR_W-1:0] tile_addr, addr_q, addr_d;
  logic              load_q, load_d, store_q, store_d, clear_q, clear_d;
  logic              done_q, done_d, err_q, err_d;
  logic              ready_q, busy_q, valid_q;

  ub_addr_gen #(
    .ADDR_W(ADDR_W), .CNT_W(CNT_W), .TILE(TILE), .MEM_SIZE(MEM_SIZE)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .latch    (latch),
    .cmd_op   (bus.cmd_op),
    .cmd_src  (bus.cmd_src),
    .cmd_dst  (bus.cmd_dst),
    .cmd_tiles(bus.cmd_tiles),
    .inc      (inc),
    .clr      (clr),
    .sel_dst  (sel_dst),
    .addr     (tile_addr),
    .last     (last),
    .range_err(range_err)
  );

  // The address generator only feeds strobes from LOAD (src) and WAIT_ACC (dst).
  assign sel_dst = (state_q == WAIT_ACC);

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    inc     = 1'b0;
    clr     = 1'b0;
    addr_d  = addr_q;
    load_d  = 1'b0;
    store_d = 1'b0;
    clear_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          latch = 1'b1;
          if (range_err)                                      err_d   = 1'b1;
          else if (bus.cmd_op == OP_NOP || bus.cmd_tiles == '0) done_d  = 1'b1;
          else if (bus.cmd_op == OP_STORE)                    state_d = WAIT_ACC;
          else                                                state_d = LOAD;
        end
      end
      LOAD: begin
        if (bus.setup_ready) begin
          load_d = 1'b1;
          addr_d = tile_addr;
          inc    = 1'b1;
          if (last) begin
            if (op_q == OP_RUN) begin
              clr     = 1'b1;
              state_d = WAIT_ACC;
            end else begin
              state_d = DONE;
            end
          end
        end
      end
      WAIT_ACC: begin
        if (bus.acc1_full && bus.acc2_full) begin
          store_d = 1'b1;
          clear_d = 1'b1;
          addr_d  = tile_addr;
          state_d = STORE;
        end
      end
      STORE: begin
        inc     = 1'b1;
        state_d = last ? DONE : WAIT_ACC;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_NOP;
      addr_q  <= '0;
      load_q  <= 1'b0;
      store_q <= 1'b0;
      clear_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch) op_q <= bus.cmd_op;
      addr_q  <= addr_d;
      load_q  <= load_d;
      store_q <= store_d;
      clear_q <= clear_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= (state_d == IDLE);
      busy_q  <= (state_d != IDLE);
      valid_q <= load_q;
    end
  end

  assign bus.cmd_ready     = ready_q;
  assign bus.busy          = busy_q;
  assign bus.ub_addr       = addr_q;
  assign bus.ub_load_input = load_q;
  assign bus.ub_store      = store_q;
  assign bus.acc_clear     = clear_q;
  assign bus.setup_valid   = valid_q;
  assign bus.done          = done_q;
  assign bus.err           = err_q;
  assign state_dbg         = state_q;

endmodule

// File: tb/tb_ub_sequencer.sv
// Directed bench for ub_sequencer: one task per scenario, expected values worked out by hand.
module tb_ub_sequencer;
  import ub_seq_pkg::*;

  localparam int ADDR_W = 13;
  localparam int CNT_W  = 4;

  logic      clk;
  logic      reset;
  ub_state_e state_dbg;
  int        total = 0;
  int        bad   = 0;
  logic [ADDR_W:0] exp_q[$];

  ub_sequencer_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  ub_sequencer #(
    .ADDR_W(ADDR_W), .MEM_SIZE(32), .TILE(4), .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // strobes = {ub_load_input, ub_store, acc_clear, done, err}
  function automatic logic [4:0] strobes();
    return {bus.ub_load_input, bus.ub_store, bus.acc_clear, bus.done, bus.err};
  endfunction

  // status = {cmd_ready, busy, setup_valid}
  function automatic logic [2:0] status();
    return {bus.cmd_ready, bus.busy, bus.setup_valid};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.cmd_valid   = 1'b0;
    bus.cmd_op      = OP_NOP;
    bus.cmd_src     = '0;
    bus.cmd_dst     = '0;
    bus.cmd_tiles   = '0;
    bus.setup_ready = 1'b0;
    bus.acc1_full   = 1'b0;
    bus.acc2_full   = 1'b0;
  endtask

  task automatic issue(input ub_op_e op, input logic [ADDR_W-1:0] src,
                       input logic [ADDR_W-1:0] dst, input logic [CNT_W-1:0] tiles);
    bus.cmd_op    = op;
    bus.cmd_src   = src;
    bus.cmd_dst   = dst;
    bus.cmd_tiles = tiles;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b1;
    tick();
    tick();
    total++; if (strobes() !== 5'b00000) begin bad++; $display("FAIL reset_strobes: got %b want 00000", strobes()); end
    total++; if (status() !== 3'b100) begin bad++; $display("FAIL reset_status: got %b want 100", status()); end
    total++; if (bus.ub_addr !== '0) begin bad++; $display("FAIL reset_addr: got %0d want 0", bus.ub_addr); end
    total++; if (state_dbg !== IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", state_dbg, IDLE); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_load_burst();
    bus.setup_ready = 1'b1;
    issue(OP_LOAD, 13'd0, 13'd0, 4'd3);
    total++; if ({status(), strobes()} !== 8'b010_00000) begin bad++; $display("FAIL burst_accept: got %b want 01000000", {status(), strobes()}); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (strobes() !== 5'b10000 || bus.ub_addr !== 13'(4 * i)) begin
        bad++; $display("FAIL burst_load%0d: got %b/%0d want 10000/%0d", i, strobes(), bus.ub_addr, 4 * i);
      end
      total++; if (bus.setup_valid !== (i > 0)) begin bad++; $display("FAIL burst_valid%0d: got %b want %b", i, bus.setup_valid, i > 0); end
    end
    tick();
    total++; if (strobes() !== 5'b00010 || status() !== 3'b101 || bus.ub_addr !== 13'd8) begin
      bad++; $display("FAIL burst_done: got %b/%b/%0d want 00010/101/8", strobes(), status(), bus.ub_addr);
    end
    tick();
    total++; if (strobes() !== 5'b00000 || status() !== 3'b100) begin bad++; $display("FAIL burst_idle: got %b/%b want 00000/100", strobes(), status()); end
    bus.setup_ready = 1'b0;
  endtask

  task automatic test_load_stall();
    bus.setup_ready = 1'b1;
    issue(OP_LOAD, 13'd4, 13'd0, 4'd2);
    tick();
    total++; if (strobes() !== 5'b10000 || bus.ub_addr !== 13'd4) begin bad++; $display("FAIL stall_first: got %b/%0d want 10000/4", strobes(), bus.ub_addr); end
    bus.setup_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (strobes() !== 5'b00000 || bus.ub_addr !== 13'd4) begin bad++; $display("FAIL stall_hold%0d: got %b/%0d want 00000/4", i, strobes(), bus.ub_addr); end
    end
    bus.setup_ready = 1'b1;
    tick();
    total++; if (strobes() !== 5'b10000 || bus.ub_addr !== 13'd8) begin bad++; $display("FAIL stall_second: got %b/%0d want 10000/8", strobes(), bus.ub_addr); end
    tick();
    total++; if (strobes() !== 5'b00010) begin bad++; $display("FAIL stall_done: got %b want 00010", strobes()); end
    bus.setup_ready = 1'b0;
    tick();
  endtask

  task automatic test_store_wait();
    issue(OP_STORE, 13'd0, 13'd16, 4'd2);
    total++; if (state_dbg !== WAIT_ACC) begin bad++; $display("FAIL store_state: got %0d want %0d", state_dbg, WAIT_ACC); end
    bus.acc1_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (strobes() !== 5'b00000) begin bad++; $display("FAIL store_acc1_only%0d: got %b want 00000", i, strobes()); end
    end
    bus.acc2_full = 1'b1;
    tick();
    total++; if (strobes() !== 5'b01100 || bus.ub_addr !== 13'd16) begin bad++; $display("FAIL store_first: got %b/%0d want 01100/16", strobes(), bus.ub_addr); end
    tick();
    total++; if (strobes() !== 5'b00000) begin bad++; $display("FAIL store_gap: got %b want 00000", strobes()); end
    bus.acc1_full = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (strobes() !== 5'b00000) begin bad++; $display("FAIL store_acc2_only%0d: got %b want 00000", i, strobes()); end
    end
    bus.acc1_full = 1'b1;
    tick();
    total++; if (strobes() !== 5'b01100 || bus.ub_addr !== 13'd20) begin bad++; $display("FAIL store_second: got %b/%0d want 01100/20", strobes(), bus.ub_addr); end
    tick();
    bus.acc1_full = 1'b0;
    bus.acc2_full = 1'b0;
    total++; if (strobes() !== 5'b00000) begin bad++; $display("FAIL store_last_gap: got %b want 00000", strobes()); end
    tick();
    total++; if (strobes() !== 5'b00010 || status() !== 3'b100) begin bad++; $display("FAIL store_done: got %b/%b want 00010/100", strobes(), status()); end
    tick();
  endtask

  task automatic test_run();
    logic [ADDR_W:0] exp;
    bit seen_done = 0;
    bit clr_pending = 0;
    int low_cnt = 0;
    exp_q.push_back({1'b0, 13'd0});
    exp_q.push_back({1'b0, 13'd4});
    exp_q.push_back({1'b1, 13'd8});
    exp_q.push_back({1'b1, 13'd12});
    bus.setup_ready = 1'b1;
    issue(OP_RUN, 13'd0, 13'd8, 4'd2);
    for (int cyc = 0; cyc < 40 && !seen_done; cyc++) begin
      tick();
      total++; if (bus.ub_load_input && bus.ub_store) begin bad++; $display("FAIL run_overlap: got 11 want not both"); end
      if (bus.ub_load_input || bus.ub_store) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL run_extra: got %b/%0d want none", bus.ub_store, bus.ub_addr);
        end else begin
          exp = exp_q.pop_front();
          if ({bus.ub_store, bus.ub_addr} !== exp) begin
            bad++; $display("FAIL run_strobe: got %b/%0d want %b/%0d", bus.ub_store, bus.ub_addr, exp[ADDR_W], exp[ADDR_W-1:0]);
          end
        end
      end
      if (bus.done) seen_done = 1;
      // accumulators: drop full one cycle after acc_clear, refill two cycles later
      if (clr_pending) begin
        bus.acc1_full = 1'b0; bus.acc2_full = 1'b0; clr_pending = 0; low_cnt = 0;
      end else if (bus.acc_clear) begin
        clr_pending = 1;
      end else if (!bus.acc1_full) begin
        low_cnt++;
        if (low_cnt >= 2) begin bus.acc1_full = 1'b1; bus.acc2_full = 1'b1; end
      end
    end
    total++; if (!seen_done) begin bad++; $display("FAIL run_timeout: got no done want done"); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL run_missing: got %0d left want 0", exp_q.size()); end
    exp_q.delete();
    drive_idle();
    tick();
  endtask

  task automatic test_range();
    bus.setup_ready = 1'b1;
    issue(OP_LOAD, 13'd28, 13'd0, 4'd2);
    total++; if (strobes() !== 5'b00001 || status() !== 3'b100) begin bad++; $display("FAIL range_load_err: got %b/%b want 00001/100", strobes(), status()); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (strobes() !== 5'b00000) begin bad++; $display("FAIL range_quiet%0d: got %b want 00000", i, strobes()); end
    end
    issue(OP_RUN, 13'd0, 13'd30, 4'd1);
    total++; if (strobes() !== 5'b00001) begin bad++; $display("FAIL range_run_err: got %b want 00001", strobes()); end
    tick();
    issue(OP_LOAD, 13'd0, 13'd0, 4'd0);
    total++; if (strobes() !== 5'b00010 || status() !== 3'b100) begin bad++; $display("FAIL zero_tiles: got %b/%b want 00010/100", strobes(), status()); end
    tick();
    total++; if (strobes() !== 5'b00000) begin bad++; $display("FAIL zero_tiles_after: got %b want 00000", strobes()); end
    issue(OP_NOP, 13'd0, 13'd0, 4'd5);
    total++; if (strobes() !== 5'b00010) begin bad++; $display("FAIL nop_done: got %b want 00010", strobes()); end
    tick();
    bus.setup_ready = 1'b0;
  endtask

  task automatic test_boundary();
    bus.setup_ready = 1'b1;
    issue(OP_LOAD, 13'd24, 13'd0, 4'd2);
    total++; if (strobes() !== 5'b00000 || status() !== 3'b010) begin bad++; $display("FAIL edge_accept: got %b/%b want 00000/010", strobes(), status()); end
    tick();
    total++; if (strobes() !== 5'b10000 || bus.ub_addr !== 13'd24) begin bad++; $display("FAIL edge_load0: got %b/%0d want 10000/24", strobes(), bus.ub_addr); end
    tick();
    total++; if (strobes() !== 5'b10000 || bus.ub_addr !== 13'd28) begin bad++; $display("FAIL edge_load1: got %b/%0d want 10000/28", strobes(), bus.ub_addr); end
    tick();
    total++; if (strobes() !== 5'b00010) begin bad++; $display("FAIL edge_done: got %b want 00010", strobes()); end
    bus.setup_ready = 1'b0;
    bus.acc1_full = 1'b1;
    bus.acc2_full = 1'b1;
    issue(OP_STORE, 13'd0, 13'd28, 4'd1);
    tick();
    total++; if (strobes() !== 5'b01100 || bus.ub_addr !== 13'd28) begin bad++; $display("FAIL edge_store: got %b/%0d want 01100/28", strobes(), bus.ub_addr); end
    tick();
    bus.acc1_full = 1'b0;
    bus.acc2_full = 1'b0;
    tick();
    total++; if (strobes() !== 5'b00010) begin bad++; $display("FAIL edge_store_done: got %b want 00010", strobes()); end
    tick();
  endtask

  task automatic test_reset_mid_run();
    bus.setup_ready = 1'b1;
    issue(OP_RUN, 13'd0, 13'd8, 4'd2);
    tick();
    tick();
    tick();
    total++; if (state_dbg !== WAIT_ACC) begin bad++; $display("FAIL mid_state: got %0d want %0d", state_dbg, WAIT_ACC); end
    reset = 1'b1;
    #2;
    total++; if ({status(), strobes()} !== 8'b100_00000 || bus.ub_addr !== '0 || state_dbg !== IDLE) begin
      bad++; $display("FAIL mid_reset: got %b/%0d/%0d want 10000000/0/0", {status(), strobes()}, bus.ub_addr, state_dbg);
    end
    bus.acc1_full = 1'b1;
    bus.acc2_full = 1'b1;
    tick();
    tick();
    total++; if (strobes() !== 5'b00000) begin bad++; $display("FAIL mid_held: got %b want 00000", strobes()); end
    reset = 1'b0;
    bus.acc1_full = 1'b0;
    bus.acc2_full = 1'b0;
    tick();
    issue(OP_LOAD, 13'd8, 13'd0, 4'd1);
    tick();
    total++; if (strobes() !== 5'b10000 || bus.ub_addr !== 13'd8) begin bad++; $display("FAIL mid_next_load: got %b/%0d want 10000/8", strobes(), bus.ub_addr); end
    tick();
    total++; if (strobes() !== 5'b00010 || status() !== 3'b101) begin bad++; $display("FAIL mid_next_done: got %b/%b want 00010/101", strobes(), status()); end
    bus.setup_ready = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_load_burst();
    test_load_stall();
    test_store_wait();
    test_run();
    test_range();
    test_boundary();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
